// File: rtl/rv_pkg.sv
// Shared core-wide constants and the {pc, instr} record carried through the
// fetch buffer.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage
// registers so downstream sees a registered value.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q;
    logic [AW-1:0]    wrPtr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    assign count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);

    // Pointers wrap by natural overflow because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + AW'(1);
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: credit-limited in-order fetch, response FIFO
// toward decode, and flush-with-discard on control-flow redirect.
module fetch_buffer
    import rv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [ILEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] respPc_q, respPc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0] count;
    logic [CW-1:0] live;
    logic [CW:0]   inUse;
    logic          accept;
    logic          respTaken;
    logic          push;
    logic          pop;
    fetch_entry_t  pushEntry;
    fetch_entry_t  headEntry;

    // Buffered words plus live in-flight words must never exceed DEPTH.
    assign live    = outstanding_q - discard_q;
    assign inUse   = {1'b0, count} + {1'b0, live};
    assign mem_req = ~rst & ~redirect & (inUse < (CW+1)'(DEPTH));
    assign mem_addr = fetchPc_q;

    assign accept    = mem_req & mem_ready;
    assign respTaken = mem_rvalid & (outstanding_q != '0);
    assign push      = respTaken & (discard_q == '0) & ~redirect;
    assign pop       = (count != '0) & out_ready & ~redirect;

    assign pushEntry.pc    = respPc_q;
    assign pushEntry.instr = mem_rdata;

    always_comb begin
        fetchPc_d     = fetchPc_q;
        respPc_d      = respPc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(respTaken);
        discard_d     = discard_q;
        if (redirect) begin
            fetchPc_d = redirect_pc;
            respPc_d  = redirect_pc;
            discard_d = outstanding_q - CW'(respTaken);
        end else begin
            if (accept) begin
                fetchPc_d = fetchPc_q + 32'd4;
            end
            if (respTaken && discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                respPc_d = respPc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q     <= RESET_PC;
            respPc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            respPc_q      <= respPc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_i  (pushEntry),
        .count_o (count),
        .head_o  (headEntry)
    );

    assign out_valid = (count != '0);
    assign out_pc    = headEntry.pc;
    assign out_instr = headEntry.instr;

    // A response with nothing outstanding means the memory broke the protocol.
    noOrphanResponse: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid && outstanding_q == '0));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed scoreboard bench for fetch_buffer with a variable-latency,
// in-order instruction memory model that returns (addr ^ DATA_KEY).
module tb_fetch_buffer;

    localparam logic [31:0] RST_PC   = 32'h0040_0000;
    localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int compared   = 0;
    int mismatched = 0;

    memReq_t     pending[$];
    logic [31:0] expQ[$];
    logic [31:0] expFetch;
    int          memLat;
    int          cycleNo = 0;
    int          reqCount = 0;
    int          popCount = 0;
    int          firstValidCycle = -1;

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0040_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: memory drives its response, the bench checks credit,
    // address and delivered words against the scoreboard, then the edge.
    task automatic applyStimulus();
        logic rv;
        logic [31:0] hpc;
        rv = (pending.size() > 0) && (pending[0].due <= cycleNo);
        mem_rvalid = rv;
        mem_rdata  = rv ? (pending[0].addr ^ DATA_KEY) : 32'h0;
        #1;
        checkOutput("mem_req_credit", mem_req, (!redirect && expQ.size() < 4));
        if (out_valid && firstValidCycle < 0) firstValidCycle = cycleNo;
        if (redirect) begin
            expQ.delete();
        end else if (out_valid && out_ready) begin
            popCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word", out_pc, 32'hFFFF_FFFF);
            end else begin
                hpc = expQ.pop_front();
                checkOutput("out_pc", out_pc, hpc);
                checkOutput("out_instr", out_instr, hpc ^ DATA_KEY);
            end
        end
        if (mem_req) checkOutput("mem_addr", mem_addr, expFetch);
        if (mem_req && mem_ready) begin
            pending.push_back('{addr: mem_addr, due: cycleNo + memLat});
            expQ.push_back(expFetch);
            expFetch = expFetch + 32'd4;
            reqCount++;
        end
        if (redirect) expFetch = redirect_pc;
        @(posedge clk);
        if (rv) void'(pending.pop_front());
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        redirect = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        pending.delete();
        expQ.delete();
        expFetch = RST_PC;
        for (int i = 0; i < cycles; i++) begin
            #1;
            checkOutput("rst_mem_req", mem_req, 1'b0);
            @(posedge clk);
            cycleNo++;
            @(negedge clk);
        end
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_mem_addr", mem_addr, RST_PC);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        rst = 1'b0;
        firstValidCycle = -1;
    endtask

    task automatic waitDrained(input string tag, input int bound);
        int n = 0;
        while (expQ.size() != 0 && n < bound) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, expQ.size(), 0);
    endtask

    task automatic checkAfterRedirect(input logic [31:0] target);
        #1;
        checkOutput("redir_out_valid", out_valid, 1'b0);
        checkOutput("redir_mem_req", mem_req, 1'b1);
        checkOutput("redir_mem_addr", mem_addr, target);
    endtask

    initial begin
        int startCycle, popsBefore, reqsBefore, tries;
        logic found;

        redirect_pc = 32'h0;
        mem_ready = 1'b1;
        out_ready = 1'b1;
        memLat = 1;
        @(negedge clk);
        applyReset(2);

        // Streaming with single-cycle memory: two-cycle first latency, then 1/cycle.
        startCycle = cycleNo;
        runCycles(6);
        checkOutput("first_valid_latency", firstValidCycle - startCycle, 2);
        popsBefore = popCount;
        runCycles(10);
        checkOutput("throughput", popCount - popsBefore, 10);

        // Back-pressure: from empty, exactly four words fetched then credit stops.
        mem_ready = 1'b0;
        waitDrained("drain_before_full", 20);
        mem_ready = 1'b1;
        out_ready = 1'b0;
        reqsBefore = reqCount;
        runCycles(8);
        checkOutput("full_req_count", reqCount - reqsBefore, 4);
        #1;
        checkOutput("full_mem_req", mem_req, 1'b0);
        checkOutput("full_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        runCycles(10);

        // Three-cycle memory, redirect with three requests in flight.
        memLat = 3;
        tries = 0;
        while (pending.size() != 3 && tries < 30) begin
            applyStimulus();
            tries++;
        end
        checkOutput("three_outstanding", pending.size(), 3);
        redirect = 1'b1;
        redirect_pc = 32'h0040_0100;
        applyStimulus();
        redirect = 1'b0;
        checkAfterRedirect(32'h0040_0100);
        runCycles(4);
        checkOutput("post_redirect_head", firstValidCycle >= 0, 1'b1);
        runCycles(12);

        // Redirect in the same cycle as a response and a pop.
        tries = 0;
        found = 1'b0;
        while (!found && tries < 30) begin
            #1;
            found = out_valid && pending.size() > 0 && pending[0].due <= cycleNo;
            if (!found) applyStimulus();
            tries++;
        end
        checkOutput("coincident_found", found, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h0040_0200;
        applyStimulus();
        redirect = 1'b0;
        checkAfterRedirect(32'h0040_0200);
        runCycles(16);

        // Random mem_ready with PC wrap-around through zero.
        memLat = 1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF0;
        applyStimulus();
        redirect = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            applyStimulus();
        end
        mem_ready = 1'b1;
        runCycles(6);

        // Reset mid-stream, then resume from RESET_PC.
        applyReset(1);
        runCycles(8);

        mem_ready = 1'b0;
        waitDrained("final_drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
